// File: rtl/header_engine_pkg.sv
// Shared constants, types and byte-window helpers for the header_engine
// preprocessing stage.
package header_engine_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

  localparam logic [7:0]  IP_PROT_TCP   = 8'd6;
  localparam logic [7:0]  IP_PROT_UDP   = 8'd17;

  // Byte offsets: ETH_HDR_LEN is from packet start, the IP_* offsets are
  // relative to the start of the IPv4 header.
  localparam logic [6:0]  ETH_HDR_LEN   = 7'd14;
  localparam logic [6:0]  VLAN_TAG_LEN  = 7'd4;
  localparam logic [6:0]  IP_PROT_OFF   = 7'd9;
  localparam logic [6:0]  IP_SA_OFF     = 7'd12;
  localparam logic [6:0]  IP_DA_OFF     = 7'd16;

  localparam int          HDR_REC_WIDTH = 105;

  typedef enum logic [1:0] {
    S_W0  = 2'd0,
    S_W1  = 2'd1,
    S_W2  = 2'd2,
    S_PAY = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic        ip;
    logic [7:0]  prot;
    logic [31:0] sp_dp;
    logic [31:0] da;
    logic [31:0] sa;
  } hdr_rec_t;

  // Byte idx of a 96-byte window (three beats, byte 0 in the LSBs).
  function automatic logic [7:0] win_byte(input logic [767:0] win,
                                          input logic [6:0]   idx);
    return win[{idx, 3'b000} +: 8];
  endfunction

  // Four consecutive bytes starting at idx, in network order.
  function automatic logic [31:0] win_word(input logic [767:0] win,
                                           input logic [6:0]   idx);
    return {win_byte(win, idx),
            win_byte(win, idx + 7'd1),
            win_byte(win, idx + 7'd2),
            win_byte(win, idx + 7'd3)};
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head entry is presented combinationally
// whenever the FIFO is not empty; the output is forced to zero when empty.
// A write on a full FIFO is accepted only when a pop happens in the same cycle.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign empty = (count == '0);
  assign full  = (count == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (do_rd) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (MAX_DEPTH_BITS+1)'(1);
        2'b01:   count <= count - (MAX_DEPTH_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/header_field_extractor.sv
// Zero-latency AXI-Stream snoop that parses Ethernet/IPv4/L4 headers into
// one record per packet, queued for the downstream classifier.
// Optional build macro HDR_VLAN_EN: accept a single 802.1Q tag.
//
// state | meaning
// ------+---------------------------------------------------------
// S_W0  | waiting for the first beat (bytes 0-31) of a packet
// S_W1  | next accepted beat is beat 1 (bytes 32-63)
// S_W2  | next accepted beat is beat 2 (bytes 64-95)
// S_PAY | header done, skipping payload until tlast
module header_field_extractor
  import header_engine_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH   = 256,
  parameter int C_AXIS_TUSER_WIDTH  = 128,
  parameter int HDR_FIFO_DEPTH_BITS = 2
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     hdr_sa,
  output logic [31:0]                     hdr_da,
  output logic [31:0]                     hdr_sp_dp,
  output logic [7:0]                      hdr_prot,
  output logic                            hdr_ip,
  output logic                            hdr_valid,
  input  logic                            hdr_ready
);

  parse_state_t state;
  logic [255:0] beat0_q;
  logic [255:0] beat1_q;
  logic [767:0] win;

  logic         rec_full;
  logic         rec_empty;
  logic         stall;
  logic         accept;
  logic         rec_wr;
  hdr_rec_t     rec_d;
  logic [HDR_REC_WIDTH-1:0] rec_q;

  logic [15:0]  eth_type;
  logic [6:0]   l3_off;
  logic [7:0]   ver_ihl;
  logic [7:0]   prot;
  logic [6:0]   l4_off;
  logic [6:0]   l4_last;
  logic         is_ip;
  logic         is_l4;
  logic [1:0]   done_beat;
  logic [1:0]   cur_beat;

  // Stall only at a packet boundary, so a packet that has started always
  // has room for its single record.
  assign stall         = (state == S_W0) && rec_full;
  assign m_axis_tvalid = s_axis_tvalid & ~stall;
  assign s_axis_tready = m_axis_tready & ~stall;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign cur_beat      = state;

  // Header window: registered earlier beats plus the live beat in its slot.
  always_comb begin
    case (state)
      S_W0:    win = {512'b0, s_axis_tdata};
      S_W1:    win = {256'b0, s_axis_tdata, beat0_q};
      default: win = {s_axis_tdata, beat1_q, beat0_q};
    endcase
  end

  // Header decode and record assembly from the current window.
  always_comb begin
    l3_off   = ETH_HDR_LEN;
    eth_type = {win_byte(win, 7'd12), win_byte(win, 7'd13)};
`ifdef HDR_VLAN_EN
    if (eth_type == ETH_TYPE_VLAN) begin
      eth_type = {win_byte(win, 7'd16), win_byte(win, 7'd17)};
      l3_off   = ETH_HDR_LEN + VLAN_TAG_LEN;
    end
`endif
    ver_ihl  = win_byte(win, l3_off);
    prot     = win_byte(win, l3_off + IP_PROT_OFF);
    is_ip    = (eth_type == ETH_TYPE_IPV4) && (ver_ihl[7:4] == 4'd4) &&
               (ver_ihl[3:0] >= 4'd5);
    is_l4    = (prot == IP_PROT_TCP) || (prot == IP_PROT_UDP);
    l4_off   = l3_off + {1'b0, ver_ihl[3:0], 2'b00};
    l4_last  = l4_off + 7'd3;

    if (!is_ip)      done_beat = 2'd0;
    else if (!is_l4) done_beat = 2'd1;
    else             done_beat = l4_last[6:5];

    rec_d = '0;
    if (is_ip && (cur_beat == done_beat)) begin
      rec_d.ip    = 1'b1;
      rec_d.prot  = prot;
      rec_d.sa    = win_word(win, l3_off + IP_SA_OFF);
      rec_d.da    = win_word(win, l3_off + IP_DA_OFF);
      rec_d.sp_dp = is_l4 ? win_word(win, l4_off) : 32'd0;
    end

    // A tlast before the completion beat writes an all-zero record.
    rec_wr = accept && (state != S_PAY) &&
             ((cur_beat == done_beat) ||
              (s_axis_tlast && (cur_beat < done_beat)));
  end

  // Hold the first two beats for fields that straddle beat boundaries.
  always_ff @(posedge axi_aclk) begin
    if (accept && (state == S_W0)) beat0_q <= s_axis_tdata;
    if (accept && (state == S_W1)) beat1_q <= s_axis_tdata;
  end

  // Beat-position FSM.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state <= S_W0;
    end else if (accept) begin
      if (s_axis_tlast) begin
        state <= S_W0;
      end else begin
        case (state)
          S_W0:    state <= S_W1;
          S_W1:    state <= S_W2;
          default: state <= S_PAY;
        endcase
      end
    end
  end

  fallthrough_small_fifo #(
    .WIDTH          (HDR_REC_WIDTH),
    .MAX_DEPTH_BITS (HDR_FIFO_DEPTH_BITS)
  ) u_rec_fifo (
    .clk   (axi_aclk),
    .reset (axi_reset),
    .din   (rec_d),
    .wr_en (rec_wr),
    .rd_en (hdr_ready),
    .dout  (rec_q),
    .full  (rec_full),
    .empty (rec_empty)
  );

  assign hdr_valid = ~rec_empty;
  assign {hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa} = rec_q;

endmodule

// File: tb/tb_header_field_extractor.sv
// Directed self-checking bench for header_field_extractor.
// Honors HDR_VLAN_EN when compiled with the same macro as the design.
module tb_header_field_extractor;
  import header_engine_pkg::*;

  logic         axi_aclk = 1'b0;
  logic         axi_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic [31:0]  hdr_sa, hdr_da, hdr_sp_dp;
  logic [7:0]   hdr_prot;
  logic         hdr_ip, hdr_valid, hdr_ready;

  int checks = 0;
  int passes = 0;

  logic [7:0]   pkt [0:95];
  logic [255:0] cur_data;
  logic [127:0] cur_user;

  header_field_extractor dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .hdr_sa(hdr_sa), .hdr_da(hdr_da), .hdr_sp_dp(hdr_sp_dp),
    .hdr_prot(hdr_prot), .hdr_ip(hdr_ip), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready)
  );

  always #5 axi_aclk = ~axi_aclk;

  function automatic logic [104:0] rec(input logic ip, input logic [7:0] pr,
                                       input logic [31:0] spdp, da, sa);
    return {ip, pr, spdp, da, sa};
  endfunction

  task automatic build_pkt(input logic [15:0] etype, input bit vlan,
                           input logic [15:0] inner, input logic [3:0] ihl,
                           input logic [7:0] pr, input logic [31:0] sa, da,
                           input logic [15:0] sp, dp);
    int l3, po;
    for (int i = 0; i < 96; i++) pkt[i] = 8'((i * 37 + 11) % 256);
    l3 = vlan ? 18 : 14;
    if (vlan) begin
      pkt[12] = 8'h81; pkt[13] = 8'h00; pkt[14] = 8'h00; pkt[15] = 8'h05;
      pkt[16] = inner[15:8]; pkt[17] = inner[7:0];
    end else begin
      pkt[12] = etype[15:8]; pkt[13] = etype[7:0];
    end
    pkt[l3]     = {4'h4, ihl};
    pkt[l3 + 9] = pr;
    for (int j = 0; j < 4; j++) begin
      pkt[l3 + 12 + j] = sa[31 - 8*j -: 8];
      pkt[l3 + 16 + j] = da[31 - 8*j -: 8];
    end
    po = l3 + 4 * int'(ihl);
    pkt[po]     = sp[15:8]; pkt[po + 1] = sp[7:0];
    pkt[po + 2] = dp[15:8]; pkt[po + 3] = dp[7:0];
  endtask

  task automatic drive_beat(input int k, input bit last);
    for (int b = 0; b < 32; b++) cur_data[8*b +: 8] = pkt[32*k + b];
    cur_user      = {4{32'hC0DE0000 | 32'(k)}};
    s_axis_tdata  = cur_data;
    s_axis_tuser  = cur_user;
    s_axis_tstrb  = '1;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic send_beat(input int k, input bit last);
    int n = 0;
    @(negedge axi_aclk);
    drive_beat(k, last);
    #1;
    while (!s_axis_tready && n < 200) begin
      @(negedge axi_aclk); #1; n++;
    end
    if (!s_axis_tready) begin
      $display("FAIL send_beat_timeout: s_axis_tready=0 required 1");
      $fatal(1, "ingress never became ready");
    end
    @(posedge axi_aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pop_record(output logic [104:0] r);
    int n = 0;
    @(negedge axi_aclk); #1;
    while (!hdr_valid && n < 100) begin
      @(negedge axi_aclk); #1; n++;
    end
    if (!hdr_valid) begin
      $display("FAIL pop_timeout: hdr_valid=0 required 1");
      $fatal(1, "record never arrived");
    end
    r = {hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa};
    hdr_ready = 1'b1;
    @(posedge axi_aclk); #1;
    hdr_ready = 1'b0;
  endtask

  task automatic test_reset;
    axi_reset = 1'b1; m_axis_tready = 1'b1; hdr_ready = 1'b0;
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd6, 32'h1, 32'h2, 16'h1, 16'h2);
    drive_beat(0, 1'b1);
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL reset_hdr_valid: got %b required 0", hdr_valid); else passes++;
    checks++; if ({hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa} !== 105'd0)
      $display("FAIL reset_fields: got %h required 0", {hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa}); else passes++;
    checks++; if (m_axis_tdata !== cur_data) $display("FAIL reset_pass_data: got %h required %h", m_axis_tdata, cur_data); else passes++;
    checks++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tuser} !== {3'b111, cur_user})
      $display("FAIL reset_pass_ctl: got %b%b%b %h required 111 %h", m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tuser, cur_user); else passes++;
    m_axis_tready = 1'b0; #1;
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b01) $display("FAIL reset_ready_follow: got %b required 01", {s_axis_tready, m_axis_tvalid}); else passes++;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    @(negedge axi_aclk);
    axi_reset = 1'b0;
  endtask

  task automatic test_tcp;
    logic [104:0] exp_r;
    exp_r = rec(1'b1, 8'd6, 32'h04D20050, 32'h0A000002, 32'h0A000001);
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    hdr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge axi_aclk);
      drive_beat(k, k == 2);
      #1;
      checks++; if (m_axis_tdata !== cur_data) $display("FAIL tcp_pass_data beat %0d: got %h required %h", k, m_axis_tdata, cur_data); else passes++;
      checks++; if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tstrb, m_axis_tuser} !== {1'b1, k == 2, 1'b1, 32'hFFFFFFFF, cur_user})
        $display("FAIL tcp_pass_ctl beat %0d: got v%b l%b r%b s%h u%h", k, m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tstrb, m_axis_tuser); else passes++;
      checks++; if (hdr_valid !== (k == 2)) $display("FAIL tcp_hdr_valid_timing beat %0d: got %b required %b", k, hdr_valid, k == 2); else passes++;
      if (k == 2) begin
        checks++; if ({hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa} !== exp_r)
          $display("FAIL tcp_record: got %h required %h", {hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa}, exp_r); else passes++;
      end
      @(posedge axi_aclk);
    end
    #1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL tcp_popped: got %b required 0", hdr_valid); else passes++;
    hdr_ready = 1'b0;
  endtask

  task automatic test_l4_variants;
    logic [104:0] r;
    // UDP, IHL=15: ports at bytes 74-77 in beat 2
    build_pkt(16'h0800, 0, 16'h0, 4'd15, 8'd17, 32'hC0A80001, 32'hC0A80002, 16'd5000, 16'd53);
    send_beat(0, 0); send_beat(1, 0);
    checks++; if (hdr_valid !== 1'b0) $display("FAIL udp15_early: got %b required 0", hdr_valid); else passes++;
    send_beat(2, 1);
    checks++; if (hdr_valid !== 1'b1) $display("FAIL udp15_done: got %b required 1", hdr_valid); else passes++;
    pop_record(r);
    checks++; if (r !== rec(1'b1, 8'd17, 32'h13880035, 32'hC0A80002, 32'hC0A80001))
      $display("FAIL udp15_record: got %h required %h", r, rec(1'b1, 8'd17, 32'h13880035, 32'hC0A80002, 32'hC0A80001)); else passes++;
    // TCP, IHL=12: ports at bytes 62-65 straddle beats 1 and 2
    build_pkt(16'h0800, 0, 16'h0, 4'd12, 8'd6, 32'h11223344, 32'h55667788, 16'hABCD, 16'h1F90);
    send_beat(0, 0); send_beat(1, 0);
    checks++; if (hdr_valid !== 1'b0) $display("FAIL tcp12_early: got %b required 0", hdr_valid); else passes++;
    send_beat(2, 1);
    pop_record(r);
    checks++; if (r !== rec(1'b1, 8'd6, 32'hABCD1F90, 32'h55667788, 32'h11223344))
      $display("FAIL tcp12_record: got %h required %h", r, rec(1'b1, 8'd6, 32'hABCD1F90, 32'h55667788, 32'h11223344)); else passes++;
    // ICMP: record after beat 1 with ports forced to zero
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd1, 32'h01020304, 32'h05060708, 16'h1111, 16'h2222);
    send_beat(0, 0);
    checks++; if (hdr_valid !== 1'b0) $display("FAIL icmp_early: got %b required 0", hdr_valid); else passes++;
    send_beat(1, 1);
    checks++; if (hdr_valid !== 1'b1) $display("FAIL icmp_done: got %b required 1", hdr_valid); else passes++;
    pop_record(r);
    checks++; if (r !== rec(1'b1, 8'd1, 32'h0, 32'h05060708, 32'h01020304))
      $display("FAIL icmp_record: got %h required %h", r, rec(1'b1, 8'd1, 32'h0, 32'h05060708, 32'h01020304)); else passes++;
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL l4_empty: got %b required 0", hdr_valid); else passes++;
  endtask

  task automatic test_nonip;
    logic [104:0] r;
    build_pkt(16'h0806, 0, 16'h0, 4'd5, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1, 16'h2);
    send_beat(0, 0);
    checks++; if (hdr_valid !== 1'b1) $display("FAIL arp_beat0_record: got %b required 1", hdr_valid); else passes++;
    send_beat(1, 1);
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1, 16'h2);
    send_beat(0, 1);
    build_pkt(16'h0800, 0, 16'h0, 4'd4, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1, 16'h2);
    send_beat(0, 0); send_beat(1, 1);
    for (int i = 0; i < 3; i++) begin
      pop_record(r);
      checks++; if (r !== 105'd0) $display("FAIL nonip_record %0d: got %h required 0", i, r); else passes++;
    end
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL nonip_count: got %b required 0", hdr_valid); else passes++;
  endtask

  task automatic test_stall;
    logic [104:0] r;
    for (int p = 1; p <= 4; p++) begin
      build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd1, 32'h0A000000 | 32'(p), 32'h0A0000FE, 16'h0, 16'h0);
      send_beat(0, 0); send_beat(1, 1);
    end
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd1, 32'h0A000005, 32'h0A0000FE, 16'h0, 16'h0);
    @(negedge axi_aclk);
    drive_beat(0, 1'b0);
    #1;
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b00) $display("FAIL stall_first: got %b required 00", {s_axis_tready, m_axis_tvalid}); else passes++;
    @(negedge axi_aclk); #1;
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b00) $display("FAIL stall_hold: got %b required 00", {s_axis_tready, m_axis_tvalid}); else passes++;
    r = {hdr_ip, hdr_prot, hdr_sp_dp, hdr_da, hdr_sa};
    hdr_ready = 1'b1;
    checks++; if (r !== rec(1'b1, 8'd1, 32'h0, 32'h0A0000FE, 32'h0A000001))
      $display("FAIL stall_head: got %h required %h", r, rec(1'b1, 8'd1, 32'h0, 32'h0A0000FE, 32'h0A000001)); else passes++;
    @(posedge axi_aclk); #1;
    hdr_ready = 1'b0;
    @(negedge axi_aclk); #1;
    checks++; if ({s_axis_tready, m_axis_tvalid} !== 2'b11) $display("FAIL stall_release: got %b required 11", {s_axis_tready, m_axis_tvalid}); else passes++;
    @(posedge axi_aclk); #1;
    s_axis_tvalid = 1'b0;
    send_beat(1, 1);
    for (int p = 2; p <= 5; p++) begin
      pop_record(r);
      checks++; if (r !== rec(1'b1, 8'd1, 32'h0, 32'h0A0000FE, 32'h0A000000 | 32'(p)))
        $display("FAIL stall_order %0d: got %h required sa %h", p, r, 32'h0A000000 | 32'(p)); else passes++;
    end
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL stall_drain: got %b required 0", hdr_valid); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [104:0] r;
    for (int p = 0; p < 2; p++) begin
      build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd1, 32'h33333333, 32'h44444444, 16'h0, 16'h0);
      send_beat(0, 0); send_beat(1, 1);
    end
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    send_beat(0, 0);
    @(negedge axi_aclk);
    drive_beat(1, 1'b0);
    axi_reset = 1'b1;
    @(posedge axi_aclk); #1;
    axi_reset = 1'b0; s_axis_tvalid = 1'b0;
    checks++; if ({hdr_valid, hdr_ip, hdr_sa} !== 34'd0) $display("FAIL rstmid_empty: got valid %b ip %b sa %h required 0", hdr_valid, hdr_ip, hdr_sa); else passes++;
    checks++; if (dut.state !== S_W0) $display("FAIL rstmid_state: got %0d required %0d", dut.state, S_W0); else passes++;
    build_pkt(16'h0800, 0, 16'h0, 4'd5, 8'd1, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'h0, 16'h0);
    send_beat(0, 0);
    checks++; if (hdr_valid !== 1'b0) $display("FAIL rstmid_w0: got %b required 0", hdr_valid); else passes++;
    send_beat(1, 1);
    pop_record(r);
    checks++; if (r !== rec(1'b1, 8'd1, 32'h0, 32'h0C0C0C0C, 32'h0B0B0B0B))
      $display("FAIL rstmid_record: got %h required %h", r, rec(1'b1, 8'd1, 32'h0, 32'h0C0C0C0C, 32'h0B0B0B0B)); else passes++;
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL rstmid_drain: got %b required 0", hdr_valid); else passes++;
  endtask

  task automatic test_vlan;
    logic [104:0] r, exp_tcp, exp_udp;
`ifdef HDR_VLAN_EN
    exp_tcp = rec(1'b1, 8'd6, 32'h04D20050, 32'h0A000002, 32'h0A000001);
    exp_udp = rec(1'b1, 8'd17, 32'h13880035, 32'hC0A80002, 32'hC0A80001);
`else
    exp_tcp = 105'd0;
    exp_udp = 105'd0;
`endif
    build_pkt(16'h0, 1, 16'h0800, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    send_beat(0, 0); send_beat(1, 0); send_beat(2, 1);
    pop_record(r);
    checks++; if (r !== exp_tcp) $display("FAIL vlan_tcp: got %h required %h", r, exp_tcp); else passes++;
    build_pkt(16'h0, 1, 16'h0800, 4'd15, 8'd17, 32'hC0A80001, 32'hC0A80002, 16'd5000, 16'd53);
    send_beat(0, 0); send_beat(1, 0); send_beat(2, 1);
    pop_record(r);
    checks++; if (r !== exp_udp) $display("FAIL vlan_udp15: got %h required %h", r, exp_udp); else passes++;
    build_pkt(16'h0, 1, 16'h8100, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    send_beat(0, 0); send_beat(1, 1);
    pop_record(r);
    checks++; if (r !== 105'd0) $display("FAIL vlan_stacked: got %h required 0", r); else passes++;
    @(negedge axi_aclk); #1;
    checks++; if (hdr_valid !== 1'b0) $display("FAIL vlan_drain: got %b required 0", hdr_valid); else passes++;
  endtask

  initial begin
    axi_reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b1; hdr_ready = 1'b0;
    test_reset();
    test_tcp();
    test_l4_variants();
    test_nonip();
    test_stall();
    test_reset_mid();
    test_vlan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
